ucsbece154b_branch_resolve: RTL and testbench

//  Execute-stage partner of the fetch-stage branch predictor. It stores the prediction metadata for each

---
 rtl/ucsbece154b_bp_pkg.sv | 42 ++++
 rtl/ucsbece154b_bp_meta_fifo.sv | 71 +++++++
 rtl/ucsbece154b_branch_resolve.sv | 175 +++++++++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_bp_pkg.sv
// Shared types and constants for the branch-resolve block.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents: bp_meta_t (per-instruction prediction metadata), br_class_e
// (NONE/BR/JMP), RISC-V opcode constants matching ucsbece154b_defines.vh,
// and classify() mapping an opcode to its branch class.
// BP_GHR_BITS fixes the stored PHT index width; the top-level NUM_GHR_BITS
// parameter is expected to equal it.
package ucsbece154b_bp_pkg;

    localparam int BP_GHR_BITS = 5;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    typedef enum logic [1:0] {
        CLASS_NONE = 2'd0,
        CLASS_BR   = 2'd1,
        CLASS_JMP  = 2'd2
    } br_class_e;

    typedef struct packed {
        logic [31:0]            pc;
        logic                   pred_taken;
        logic [31:0]            pred_target;
        logic [BP_GHR_BITS-1:0] phtaddr;
    } bp_meta_t;

    function automatic br_class_e classify(input logic [6:0] op);
        br_class_e cls;
        cls = CLASS_NONE;
        if (op == instr_branch_op) begin
            cls = CLASS_BR;
        end else if ((op == instr_jal_op) || (op == instr_jalr_op)) begin
            cls = CLASS_JMP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_meta_fifo.sv
// In-flight prediction metadata FIFO between fetch and execute.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: the caller gates push with full (push+pop while full is legal); flush_i empties it.
//
// Ports: clk, reset_ni (async active-low), flush_i, push_i/wdata_i,
// pop_i/rdata_o (head entry), full_o, empty_o, count_o.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ucsbece154b_bp_meta_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution: compares stored predictions with E outcomes and trains the predictor.
// Latency: update/redirect pulses are registered, appearing 1 cycle after the pop.
// Backpressure: fetch_stall_o when the metadata FIFO is full and not popping; a redirect flushes the FIFO next cycle.
//
// Ports: fetch side (fetch_valid_i, fetch_pc_i, pred_*_i, fetch_stall_o),
// execute side (ex_valid_i, ex_op_i, ex_taken_i, ex_target_i),
// predictor update (btb_*, pht_*, ghr_reset_o), redirect_o/redirect_pc_o,
// sticky meta_underflow_o.
// Optional macro BRANCH_STATS_EN adds saturating br_count_o / mispred_count_o.
module ucsbece154b_branch_resolve
    import ucsbece154b_bp_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int META_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               reset_ni,
    input  logic                               fetch_valid_i,
    input  logic [31:0]                        fetch_pc_i,
    input  logic                               pred_taken_i,
    input  logic [31:0]                        pred_target_i,
    input  logic [NUM_GHR_BITS-1:0]            pred_phtaddr_i,
    output logic                               fetch_stall_o,
    input  logic                               ex_valid_i,
    input  logic [6:0]                         ex_op_i,
    input  logic                               ex_taken_i,
    input  logic [31:0]                        ex_target_i,
    output logic                               btb_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] btb_waddr_o,
    output logic [31:0]                        btb_wdata_o,
    output logic                               pht_we_o,
    output logic                               pht_inc_o,
    output logic [NUM_GHR_BITS-1:0]            pht_waddr_o,
    output logic                               ghr_reset_o,
    output logic                               redirect_o,
    output logic [31:0]                        redirect_pc_o,
`ifdef BRANCH_STATS_EN
    output logic [31:0]                        br_count_o,
    output logic [31:0]                        mispred_count_o,
`endif
    output logic                               meta_underflow_o
);

    localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

    bp_meta_t                    push_meta, head_meta;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(META_DEPTH):0] fifo_count;
    logic                        flush, pop, push, resolve, tgt_miss, mispred;
    br_class_e                   cls;

    logic                        btb_we_q,    btb_we_d;
    logic [BTB_IDX_W-1:0]        btb_waddr_q, btb_waddr_d;
    logic [31:0]                 btb_wdata_q;
    logic                        pht_we_q,    pht_we_d;
    logic                        pht_inc_q,   pht_inc_d;
    logic [NUM_GHR_BITS-1:0]     pht_waddr_q, pht_waddr_d;
    logic                        redirect_q,  redirect_d;
    logic [31:0]                 redirect_pc_q, redirect_pc_d;
    logic                        underflow_q, underflow_d;

    // The cycle after a mispredict pop is the flush cycle: the E-stage
    // instruction and any fetch in that cycle are wrong-path.
    assign flush = redirect_q;
    assign pop   = ex_valid_i & (fifo_count != '0) & ~flush;
    assign fetch_stall_o = fifo_full & ~pop;
    assign push  = fetch_valid_i & ~fetch_stall_o & ~flush;

    always_comb begin
        push_meta             = '0;
        push_meta.pc          = fetch_pc_i;
        push_meta.pred_taken  = pred_taken_i;
        push_meta.pred_target = pred_target_i;
        push_meta.phtaddr     = BP_GHR_BITS'(pred_phtaddr_i);
    end

    ucsbece154b_bp_meta_fifo #(
        .DEPTH (META_DEPTH),
        .W     ($bits(bp_meta_t))
    ) u_meta_fifo (
        .clk      (clk),
        .reset_ni (reset_ni),
        .flush_i  (flush),
        .push_i   (push),
        .wdata_i  (push_meta),
        .pop_i    (pop),
        .rdata_o  (head_meta),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign cls      = classify(ex_op_i);
    assign resolve  = pop & (cls != CLASS_NONE);
    assign tgt_miss = (head_meta.pred_target != ex_target_i);

    always_comb begin
        mispred = 1'b0;
        if (cls == CLASS_BR) begin
            mispred = (head_meta.pred_taken != ex_taken_i) | (ex_taken_i & tgt_miss);
        end else if (cls == CLASS_JMP) begin
            mispred = ~head_meta.pred_taken | tgt_miss;
        end
    end

    always_comb begin
        btb_we_d      = resolve & ex_taken_i & tgt_miss;
        pht_we_d      = pop & (cls == CLASS_BR);
        pht_inc_d     = pop & (cls == CLASS_BR) & ex_taken_i;
        redirect_d    = resolve & mispred;
        btb_waddr_d   = head_meta.pc[BTB_IDX_W+1:2];
        pht_waddr_d   = NUM_GHR_BITS'(head_meta.phtaddr);
        redirect_pc_d = ex_taken_i ? ex_target_i : (head_meta.pc + 32'd4);
        underflow_d   = underflow_q | (ex_valid_i & fifo_empty & ~flush);
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            btb_we_q      <= 1'b0;
            btb_waddr_q   <= '0;
            btb_wdata_q   <= '0;
            pht_we_q      <= 1'b0;
            pht_inc_q     <= 1'b0;
            pht_waddr_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            btb_we_q    <= btb_we_d;
            pht_we_q    <= pht_we_d;
            pht_inc_q   <= pht_inc_d;
            redirect_q  <= redirect_d;
            underflow_q <= underflow_d;
            // Payload registers hold between resolves; they are only
            // meaningful while their strobe is high.
            if (resolve) begin
                btb_waddr_q   <= btb_waddr_d;
                btb_wdata_q   <= ex_target_i;
                pht_waddr_q   <= pht_waddr_d;
                redirect_pc_q <= redirect_pc_d;
            end
        end
    end

    assign btb_we_o         = btb_we_q;
    assign btb_waddr_o      = btb_waddr_q;
    assign btb_wdata_o      = btb_wdata_q;
    assign pht_we_o         = pht_we_q;
    assign pht_inc_o        = pht_inc_q;
    assign pht_waddr_o      = pht_waddr_q;
    assign ghr_reset_o      = redirect_q;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign meta_underflow_o = underflow_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, mis_cnt_q;

    // Counters advance on the same edge that registers the pulses.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != '1))     br_cnt_q  <= br_cnt_q + 32'd1;
            if (redirect_d && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve.
// Latency: checks registered outputs one cycle after each driven cycle.
// Backpressure: the reference model tracks the queue, stall and flush cycles.
module tb_ucsbece154b_branch_resolve;

    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_ALU  = 7'h33;
    localparam int         DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic [4:0]  pred_phtaddr_i;
    logic        fetch_stall_o;
    logic        ex_valid_i;
    logic [6:0]  ex_op_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        btb_we_o;
    logic [4:0]  btb_waddr_o;
    logic [31:0] btb_wdata_o;
    logic        pht_we_o;
    logic        pht_inc_o;
    logic [4:0]  pht_waddr_o;
    logic        ghr_reset_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        meta_underflow_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_o;
    logic [31:0] mispred_count_o;
`endif

    always #5 clk = ~clk;

    ucsbece154b_branch_resolve dut (
        .clk              (clk),
        .reset_ni         (reset_ni),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_pc_i       (fetch_pc_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .pred_phtaddr_i   (pred_phtaddr_i),
        .fetch_stall_o    (fetch_stall_o),
        .ex_valid_i       (ex_valid_i),
        .ex_op_i          (ex_op_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .btb_we_o         (btb_we_o),
        .btb_waddr_o      (btb_waddr_o),
        .btb_wdata_o      (btb_wdata_o),
        .pht_we_o         (pht_we_o),
        .pht_inc_o        (pht_inc_o),
        .pht_waddr_o      (pht_waddr_o),
        .ghr_reset_o      (ghr_reset_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
`ifdef BRANCH_STATS_EN
        .br_count_o       (br_count_o),
        .mispred_count_o  (mispred_count_o),
`endif
        .meta_underflow_o (meta_underflow_o)
    );

    // Reference model: a queue of in-flight predictions plus the expected
    // registered outputs for the cycle after each edge.
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [4:0]  pha;
    } ent_t;

    ent_t        mq[$];
    logic        e_btb_we, e_pht_we, e_inc, e_redir, e_uf;
    logic [4:0]  e_waddr, e_pha;
    logic [31:0] e_wdata, e_rpc;
    logic [31:0] e_br, e_mis;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        mq.delete();
        e_btb_we = 0; e_pht_we = 0; e_inc = 0; e_redir = 0; e_uf = 0;
        e_waddr = 0; e_pha = 0; e_wdata = 0; e_rpc = 0; e_br = 0; e_mis = 0;
    endtask

    task automatic check_outputs();
        check_val("redirect", redirect_o, e_redir);
        check_val("ghr_reset", ghr_reset_o, e_redir);
        check_val("btb_we", btb_we_o, e_btb_we);
        check_val("pht_we", pht_we_o, e_pht_we);
        check_val("underflow", meta_underflow_o, e_uf);
        if (e_btb_we) begin
            check_val("btb_waddr", btb_waddr_o, e_waddr);
            check_val("btb_wdata", btb_wdata_o, e_wdata);
        end
        if (e_pht_we) begin
            check_val("pht_inc", pht_inc_o, e_inc);
            check_val("pht_waddr", pht_waddr_o, e_pha);
        end
        if (e_redir) check_val("redirect_pc", redirect_pc_o, e_rpc);
`ifdef BRANCH_STATS_EN
        check_val("br_count", br_count_o, e_br);
        check_val("mispred_count", mispred_count_o, e_mis);
`endif
    endtask

    // Called at a negedge: drive one cycle, check the combinational stall,
    // advance the model, and check registered outputs at the next negedge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic [4:0] pha,
                        input logic ev, input logic [6:0] op, input logic et,
                        input logic [31:0] etgt);
        bit   flush, pop, stall, isbr, isjmp, mis;
        ent_t h, n;
        fetch_valid_i = fv; fetch_pc_i = pc; pred_taken_i = pt;
        pred_target_i = ptgt; pred_phtaddr_i = pha;
        ex_valid_i = ev; ex_op_i = op; ex_taken_i = et; ex_target_i = etgt;
        #1;
        flush = e_redir;
        pop   = ev && (mq.size() != 0) && !flush;
        stall = (mq.size() == DEPTH) && !pop;
        check_val("fetch_stall", fetch_stall_o, stall);

        if (ev && (mq.size() == 0) && !flush) e_uf = 1'b1;
        e_btb_we = 0; e_pht_we = 0; e_inc = 0; e_redir = 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                h     = mq.pop_front();
                isbr  = (op == OP_BR);
                isjmp = (op == OP_JAL) || (op == OP_JALR);
                if (isbr || isjmp) begin
                    if (isbr) mis = (h.pt != et) || (et && (h.tgt != etgt));
                    else      mis = !h.pt || (h.tgt != etgt);
                    e_btb_we = et && (h.tgt != etgt);
                    e_pht_we = isbr;
                    e_inc    = isbr && et;
                    e_redir  = mis;
                    e_waddr  = 5'((h.pc / 4) % 32);
                    e_wdata  = etgt;
                    e_pha    = h.pha;
                    e_rpc    = et ? etgt : h.pc + 32'd4;
                    if (e_br != 32'hffff_ffff) e_br = e_br + 1;
                    if (mis && (e_mis != 32'hffff_ffff)) e_mis = e_mis + 1;
                end
            end
            if (fv && !stall) begin
                n.pc = pc; n.pt = pt; n.tgt = ptgt; n.pha = pha;
                mq.push_back(n);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, OP_ALU, 0, 0);
    endtask

    task automatic push_only(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt, input logic [4:0] pha);
        step(1, pc, pt, ptgt, pha, 0, OP_ALU, 0, 0);
    endtask

    task automatic pop_only(input logic [6:0] op, input logic et, input logic [31:0] etgt);
        step(0, 0, 0, 0, 0, 1, op, et, etgt);
    endtask

    initial begin
        reset_ni = 0;
        fetch_valid_i = 0; fetch_pc_i = 0; pred_taken_i = 0; pred_target_i = 0;
        pred_phtaddr_i = 0; ex_valid_i = 0; ex_op_i = OP_ALU; ex_taken_i = 0; ex_target_i = 0;
        reset_model();
        repeat (2) @(negedge clk);
        check_outputs();
        check_val("rst_stall", fetch_stall_o, 1'b0);
        check_val("rst_rpc", redirect_pc_o, 32'h0);
        reset_ni = 1;

        // FIFO fill, drop when full, push+pop while full
        push_only(32'h100, 0, 32'h0, 5'd1);
        push_only(32'h104, 0, 32'h0, 5'd2);
        push_only(32'h108, 0, 32'h0, 5'd3);
        push_only(32'h10C, 0, 32'h0, 5'd4);
        check_val("t1_full_stall", fetch_stall_o, 1'b1);
        push_only(32'h110, 0, 32'h0, 5'd5);
        step(1, 32'h114, 0, 32'h0, 5'd6, 1, OP_ALU, 0, 0);
        pop_only(OP_BR, 0, 32'h0);
        check_val("t1_head_after_drop", pht_waddr_o, 5'd2);
        pop_only(OP_BR, 0, 32'h0);
        pop_only(OP_BR, 0, 32'h0);
        pop_only(OP_BR, 0, 32'h0);
        check_val("t1_pushpop_full_kept", pht_waddr_o, 5'd6);

        // BR predicted not-taken, actually taken
        push_only(32'h100, 0, 32'h0, 5'd9);
        pop_only(OP_BR, 1, 32'h140);
        check_val("t2_btb_we", btb_we_o, 1'b1);
        check_val("t2_waddr", btb_waddr_o, 5'd0);
        check_val("t2_wdata", btb_wdata_o, 32'h140);
        check_val("t2_pht_inc", pht_inc_o, 1'b1);
        check_val("t2_rpc", redirect_pc_o, 32'h140);
        idle();

        // BR predicted taken, actually not taken
        push_only(32'h104, 1, 32'h200, 5'd10);
        pop_only(OP_BR, 0, 32'h108);
        check_val("t3_pht_inc", pht_inc_o, 1'b0);
        check_val("t3_btb_we", btb_we_o, 1'b0);
        check_val("t3_rpc", redirect_pc_o, 32'h108);
        check_val("t3_ghr", ghr_reset_o, 1'b1);
        idle();

        // Correctly predicted jal; FIFO advances by one
        push_only(32'h10C, 1, 32'h300, 5'd11);
        push_only(32'h110, 0, 32'h0, 5'd12);
        pop_only(OP_JAL, 1, 32'h300);
        check_val("t4_redirect", redirect_o, 1'b0);
        pop_only(OP_BR, 0, 32'h0);
        check_val("t4_next_head", pht_waddr_o, 5'd12);

        // Mispredict with younger entries queued and a push in the flush cycle
        push_only(32'h400, 0, 32'h0, 5'd13);
        push_only(32'h404, 0, 32'h0, 5'd14);
        push_only(32'h408, 0, 32'h0, 5'd15);
        pop_only(OP_BR, 1, 32'h500);
        push_only(32'h504, 0, 32'h0, 5'd16);
        check_val("t5_no_uf_yet", meta_underflow_o, 1'b0);
        pop_only(OP_BR, 0, 32'h0);
        check_val("t5_underflow", meta_underflow_o, 1'b1);

        // Asynchronous reset mid-redirect
        reset_ni = 0;
        #2;
        reset_model();
        reset_ni = 1;
        push_only(32'h200, 0, 32'h0, 5'd7);
        pop_only(OP_BR, 1, 32'h240);
        check_val("t6_pre_redirect", redirect_o, 1'b1);
        fetch_valid_i = 0; ex_valid_i = 0;
        #2 reset_ni = 0;
        #1;
        reset_model();
        check_outputs();
        check_val("t6_rpc_zero", redirect_pc_o, 32'h0);
        check_val("t6_wdata_zero", btb_wdata_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1;
        idle();
        idle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        fv, pt, ev, et;
            logic [31:0] pc, ptgt, etgt, htgt;
            logic [4:0]  pha;
            logic [6:0]  op;
            int          k;
            fv   = ($urandom % 4) != 0;
            pc   = $urandom & 32'hffff_fffc;
            pt   = $urandom % 2;
            ptgt = $urandom & 32'h0000_fffc;
            pha  = 5'($urandom);
            ev   = ($urandom % 2) != 0;
            k    = $urandom % 4;
            op   = (k == 0) ? OP_BR : (k == 1) ? OP_JAL : (k == 2) ? OP_JALR : OP_ALU;
            htgt = (mq.size() != 0) ? mq[0].tgt : 32'h0;
            etgt = (($urandom % 3) != 0) ? htgt : ($urandom & 32'h0000_fffc);
            et   = ((op == OP_JAL) || (op == OP_JALR)) ? 1'b1 : 1'($urandom % 2);
            step(fv, pc, pt, ptgt, pha, ev, op, et, etgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
